// File: rtl/rs_encode.sv
// Systematic RS(15,9) encoder over GF(16) (x^4+x+1): 9 message symbols in, 15-symbol codeword out.
// Serial 6-stage parity LFSR, one symbol per clock; codeword ready 10 edges after accept, requests ignored while busy.
module rs_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_en,
  input  logic [35:0] datain,
  output logic        busy,
  output logic        data_rdy,
  output logic [59:0] dataout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // g5..g0 of the generator polynomial (monic x^6 term implicit)
  localparam logic [5:0][3:0] G = {4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};

  state_t           state, state_nxt;
  logic [35:0]      msg;
  logic [5:0][3:0]  lfsr, lfsr_nxt;
  logic [3:0]       cnt;
  logic [3:0]       fb;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      p = {p[2:0], 1'b0} ^ (p[3] ? 4'b0011 : 4'b0000);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  always_comb begin
    fb          = msg[35:32] ^ lfsr[5];
    lfsr_nxt    = '0;
    lfsr_nxt[0] = gf_mul(G[0], fb);
    for (int k = 1; k < 6; k++) begin
      lfsr_nxt[k] = lfsr[k-1] ^ gf_mul(G[k], fb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_en) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg      <= '0;
      lfsr     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      data_rdy <= 1'b0;
      dataout  <= '0;
    end else begin
      data_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (data_en) begin
            msg  <= datain;
            lfsr <= '0;
            cnt  <= 4'd9;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          // nine rotations bring the message back to its original alignment
          lfsr <= lfsr_nxt;
          msg  <= {msg[31:0], msg[35:32]};
          cnt  <= cnt - 4'd1;
        end
        DONE: begin
          dataout  <= {msg, lfsr};
          data_rdy <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
